// File: rtl/mem_pkg.sv
// Shared types and helpers for the multicycle CPU memory responder.
package mem_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } MemState;

  // A request is rejected if it asks for both operations, is not word aligned,
  // or addresses beyond the 2**addr_w words of storage.
  function automatic logic mem_req_error(input logic              rd,
                                         input logic              wr,
                                         input logic [WORD_W-1:0] addr,
                                         input int                addr_w);
    logic hiBad;
    hiBad = 1'b0;
    for (int i = 0; i < WORD_W; i++) begin
      if ((i >= addr_w + 2) && addr[i]) begin
        hiBad = 1'b1;
      end
    end
    return (rd && wr) || (addr[1:0] != 2'b00) || hiBad;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Memory bus between the control unit/datapath (master) and the responder (slave).
interface mem_responder_if;
  import mem_pkg::*;

  logic [WORD_W-1:0] Address;
  logic [WORD_W-1:0] WriteData;
  logic              MemRead;
  logic              MemWrite;
  logic [WORD_W-1:0] MemData;
  logic              MemReady;
  logic              MemBusy;
  logic              MemError;

  modport master (
    output Address, WriteData, MemRead, MemWrite,
    input  MemData, MemReady, MemBusy, MemError
  );

  modport slave (
    input  Address, WriteData, MemRead, MemWrite,
    output MemData, MemReady, MemBusy, MemError
  );

endinterface

// File: rtl/mem_array.sv
// Word storage: one synchronous write port; the read word is captured by the
// responder's MemData register, so the read here is a plain array lookup.
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] words [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      words[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = words[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory slave: accepts one word request, waits LATENCY cycles,
// performs the access, then pulses MemReady (with MemError on rejection).
module mem_responder
  import mem_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 8
) (
  input logic            clock,
  input logic            reset,
  mem_responder_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  MemState           state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              isWrite_q, isWrite_d;
  logic              isErr_q, isErr_d;
  logic [WORD_W-1:0] memData_q, memData_d;

  logic              newReq;
  logic              newErr;
  logic              accEn;
  logic              accWrite;
  logic [ADDR_W-1:0] accIdx;
  logic [WORD_W-1:0] accWdata;
  logic [WORD_W-1:0] arrayRdata;

  assign newReq = bus.MemRead | bus.MemWrite;
  assign newErr = mem_req_error(bus.MemRead, bus.MemWrite, bus.Address, ADDR_W);

  // With zero latency the access happens on the accepting edge, so it must use
  // the live bus values rather than the (not yet loaded) latched ones.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    isWrite_d = isWrite_q;
    isErr_d   = isErr_q;
    memData_d = memData_q;
    accEn     = 1'b0;
    accWrite  = isWrite_q;
    accIdx    = idx_q;
    accWdata  = wdata_q;

    case (state_q)
      IDLE: begin
        if (newReq) begin
          idx_d     = bus.Address[ADDR_W+1:2];
          wdata_d   = bus.WriteData;
          isWrite_d = bus.MemWrite;
          isErr_d   = newErr;
          if (newErr) begin
            cnt_d   = '0;
            state_d = DONE;
          end else if (LATENCY == 0) begin
            cnt_d    = '0;
            state_d  = DONE;
            accEn    = 1'b1;
            accWrite = bus.MemWrite;
            accIdx   = bus.Address[ADDR_W+1:2];
            accWdata = bus.WriteData;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          accEn   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accEn && !accWrite) begin
      memData_d = arrayRdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      isWrite_q <= 1'b0;
      isErr_q   <= 1'b0;
      memData_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      isWrite_q <= isWrite_d;
      isErr_q   <= isErr_d;
      memData_q <= memData_d;
    end
  end

  mem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clock   (clock),
    .wr_en_i (accEn & accWrite),
    .addr_i  (accIdx),
    .wdata_i (accWdata),
    .rdata_o (arrayRdata)
  );

  assign bus.MemData  = memData_q;
  assign bus.MemReady = (state_q == DONE);
  assign bus.MemBusy  = (state_q != IDLE);
  assign bus.MemError = (state_q == DONE) && isErr_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: one LATENCY=2 and one LATENCY=0 instance
// checked against a word-array reference model with request-level timing rules.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int ADDR_W = 8;
  localparam int NWORDS = 2**ADDR_W;
  localparam int LAT [2] = '{2, 0};

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_responder_if bus2 ();
  mem_responder_if bus0 ();

  mem_responder #(.LATENCY(2), .ADDR_W(ADDR_W)) dut2 (.clock(clock), .reset(reset), .bus(bus2));
  mem_responder #(.LATENCY(0), .ADDR_W(ADDR_W)) dut0 (.clock(clock), .reset(reset), .bus(bus0));

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model [2][NWORDS];
  logic [31:0] expData [2];

  task automatic drive(input int d, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] w);
    if (d == 0) begin
      bus2.MemRead = rd; bus2.MemWrite = wr; bus2.Address = a; bus2.WriteData = w;
    end else begin
      bus0.MemRead = rd; bus0.MemWrite = wr; bus0.Address = a; bus0.WriteData = w;
    end
  endtask

  function automatic logic ready_of(input int d);
    return (d == 0) ? bus2.MemReady : bus0.MemReady;
  endfunction
  function automatic logic busy_of(input int d);
    return (d == 0) ? bus2.MemBusy : bus0.MemBusy;
  endfunction
  function automatic logic err_of(input int d);
    return (d == 0) ? bus2.MemError : bus0.MemError;
  endfunction
  function automatic logic [31:0] data_of(input int d);
    return (d == 0) ? bus2.MemData : bus0.MemData;
  endfunction

  // Reference behaviour of one request: rejection rules, array update, read data.
  task automatic model_access(input int d, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic err);
    int w;
    err = (rd && wr) || (addr % 4 != 0) || (addr >= NWORDS * 4);
    if (!err) begin
      w = int'(addr / 4);
      if (wr) model[d][w] = wdata;
      else    expData[d]  = model[d][w];
    end
  endtask

  task automatic run_req(input int d, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input bit scramble, output int cyc, output int busyCnt,
                         output logic gotErr, output logic [31:0] gotData,
                         output logic readyAfter);
    @(negedge clock);
    drive(d, rd, wr, addr, wdata);
    cyc = 0; busyCnt = 0; gotErr = 1'b0; gotData = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); #1;
      if (busy_of(d)) busyCnt++;
      if (scramble && k == 1) drive(d, rd, wr, $urandom, $urandom);
      if (ready_of(d)) begin
        cyc = k; gotErr = err_of(d); gotData = data_of(d);
        break;
      end
    end
    drive(d, 1'b0, 1'b0, '0, '0);
    @(posedge clock); #1;
    readyAfter = ready_of(d);
  endtask

  task automatic test_reset();
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    #3 reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if ({ready_of(d), busy_of(d), err_of(d)} !== 3'b000 || data_of(d) !== 32'h0) begin
        miscompares++;
        $display("[TB] FAIL reset_outputs dut%0d: got rdy/busy/err=%b%b%b data=%h, need 000 data=00000000",
                 d, ready_of(d), busy_of(d), err_of(d), data_of(d));
      end
      expData[d] = '0;
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_preload();
    int cyc, busyCnt; logic gotErr, ra, eErr; logic [31:0] gotData, wv;
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) begin
        wv = $urandom;
        model_access(d, 1'b0, 1'b1, 32'(w * 4), wv, eErr);
        run_req(d, 1'b0, 1'b1, 32'(w * 4), wv, 1'b0, cyc, busyCnt, gotErr, gotData, ra);
        vectors++;
        if (cyc !== LAT[d] + 1 || gotErr !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL preload_write dut%0d w%0d: got cycles=%0d err=%b, need cycles=%0d err=0",
                   d, w, cyc, gotErr, LAT[d] + 1);
        end
      end
    end
  endtask

  task automatic test_write_read();
    int cyc, busyCnt; logic gotErr, ra, eErr; logic [31:0] gotData;
    model_access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, eErr);
    run_req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, cyc, busyCnt, gotErr, gotData, ra);
    vectors++;
    if (cyc !== 3 || busyCnt !== 3) begin
      miscompares++;
      $display("[TB] FAIL wr_timing: got cycles=%0d busy=%0d, need 3/3", cyc, busyCnt);
    end
    model_access(0, 1'b1, 1'b0, 32'h10, '0, eErr);
    run_req(0, 1'b1, 1'b0, 32'h10, '0, 1'b0, cyc, busyCnt, gotErr, gotData, ra);
    vectors++;
    if (cyc !== 3 || busyCnt !== 3 || gotData !== 32'hDEADBEEF) begin
      miscompares++;
      $display("[TB] FAIL rd_deadbeef: got cycles=%0d busy=%0d data=%h, need 3/3 data=deadbeef",
               cyc, busyCnt, gotData);
    end
  endtask

  task automatic test_errors();
    int cyc, busyCnt; logic gotErr, ra, eErr; logic [31:0] gotData;
    logic [31:0] addrs [2] = '{32'h12, 32'h400};
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 2; i++) begin
        model_access(d, 1'b1, 1'b0, addrs[i], '0, eErr);
        run_req(d, 1'b1, 1'b0, addrs[i], '0, 1'b0, cyc, busyCnt, gotErr, gotData, ra);
        vectors++;
        if (cyc !== 1 || gotErr !== 1'b1 || gotData !== expData[d] || eErr !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL err_addr dut%0d a=%h: got cycles=%0d err=%b data=%h, need 1/1 data=%h",
                   d, addrs[i], cyc, gotErr, gotData, expData[d]);
        end
      end
    end
  endtask

  task automatic test_both_rw();
    int cyc, busyCnt; logic gotErr, ra, eErr; logic [31:0] gotData, junk;
    junk = $urandom;
    model_access(0, 1'b1, 1'b1, 32'h8, junk, eErr);
    run_req(0, 1'b1, 1'b1, 32'h8, junk, 1'b0, cyc, busyCnt, gotErr, gotData, ra);
    vectors++;
    if (cyc !== 1 || gotErr !== 1'b1 || gotData !== expData[0]) begin
      miscompares++;
      $display("[TB] FAIL rw_both: got cycles=%0d err=%b data=%h, need 1/1 data=%h",
               cyc, gotErr, gotData, expData[0]);
    end
    model_access(0, 1'b1, 1'b0, 32'h8, '0, eErr);
    run_req(0, 1'b1, 1'b0, 32'h8, '0, 1'b0, cyc, busyCnt, gotErr, gotData, ra);
    vectors++;
    if (gotErr !== 1'b0 || gotData !== expData[0]) begin
      miscompares++;
      $display("[TB] FAIL rw_both_after: got err=%b data=%h, need 0 data=%h", gotErr, gotData, expData[0]);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0, firstK = 0, secondK = 0;
    @(negedge clock);
    drive(1, 1'b1, 1'b0, 32'h0, '0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clock); #1;
      if (ready_of(1)) begin
        pulses++;
        if (pulses == 1) begin
          firstK = k;
          vectors++;
          if (data_of(1) !== model[1][0]) begin
            miscompares++;
            $display("[TB] FAIL b2b_data0: got %h, need %h", data_of(1), model[1][0]);
          end
          drive(1, 1'b1, 1'b0, 32'h4, '0);
        end else if (pulses == 2) begin
          secondK = k;
          vectors++;
          if (data_of(1) !== model[1][1]) begin
            miscompares++;
            $display("[TB] FAIL b2b_data1: got %h, need %h", data_of(1), model[1][1]);
          end
          drive(1, 1'b0, 1'b0, '0, '0);
        end
      end
    end
    drive(1, 1'b0, 1'b0, '0, '0);
    expData[1] = model[1][1];
    vectors++;
    if (pulses !== 2 || firstK !== 1 || secondK !== 3) begin
      miscompares++;
      $display("[TB] FAIL b2b_pulses: got count=%0d at k=%0d,%0d, need 2 at k=1,3", pulses, firstK, secondK);
    end
  endtask

  task automatic test_latched_inputs();
    int cyc, busyCnt; logic gotErr, ra, eErr; logic [31:0] gotData, wv;
    wv = $urandom;
    model_access(0, 1'b0, 1'b1, 32'h30, wv, eErr);
    run_req(0, 1'b0, 1'b1, 32'h30, wv, 1'b1, cyc, busyCnt, gotErr, gotData, ra);
    vectors++;
    if (cyc !== 3 || gotErr !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL latch_write: got cycles=%0d err=%b, need 3/0", cyc, gotErr);
    end
    model_access(0, 1'b1, 1'b0, 32'h30, '0, eErr);
    run_req(0, 1'b1, 1'b0, 32'h30, '0, 1'b0, cyc, busyCnt, gotErr, gotData, ra);
    vectors++;
    if (gotData !== expData[0]) begin
      miscompares++;
      $display("[TB] FAIL latch_readback: got %h, need %h", gotData, expData[0]);
    end
  endtask

  task automatic test_reset_abort();
    int cyc, busyCnt; logic gotErr, ra, eErr; logic [31:0] gotData, oldv;
    oldv = $urandom;
    model_access(0, 1'b0, 1'b1, 32'h20, oldv, eErr);
    run_req(0, 1'b0, 1'b1, 32'h20, oldv, 1'b0, cyc, busyCnt, gotErr, gotData, ra);
    @(negedge clock);
    drive(0, 1'b0, 1'b1, 32'h20, 32'h11111111);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    vectors++;
    if ({bus2.MemReady, bus2.MemBusy, bus2.MemError} !== 3'b000 || bus2.MemData !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL abort_outputs: got rdy/busy/err=%b%b%b data=%h, need 000 data=00000000",
               bus2.MemReady, bus2.MemBusy, bus2.MemError, bus2.MemData);
    end
    expData[0] = '0;
    expData[1] = '0;
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    reset = 1'b1;
    model_access(0, 1'b1, 1'b0, 32'h20, '0, eErr);
    run_req(0, 1'b1, 1'b0, 32'h20, '0, 1'b0, cyc, busyCnt, gotErr, gotData, ra);
    vectors++;
    if (gotData !== oldv || cyc !== 3) begin
      miscompares++;
      $display("[TB] FAIL abort_readback: got data=%h cycles=%0d, need %h/3", gotData, cyc, oldv);
    end
  endtask

  task automatic test_random();
    int cyc, busyCnt, kind, eCyc; logic gotErr, ra, eErr, rd, wr; logic [31:0] gotData, addr, wv;
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 25; n++) begin
        kind = int'($urandom_range(0, 9));
        addr = 32'($urandom_range(0, 15)) * 4;
        wr   = $urandom_range(0, 1) == 1;
        rd   = !wr;
        wv   = $urandom;
        if (kind == 7) addr = addr | 32'($urandom_range(1, 3));
        if (kind == 8) addr = addr | (32'h400 << $urandom_range(0, 21));
        if (kind == 9) begin rd = 1'b1; wr = 1'b1; end
        model_access(d, rd, wr, addr, wv, eErr);
        eCyc = eErr ? 1 : LAT[d] + 1;
        run_req(d, rd, wr, addr, wv, 1'b0, cyc, busyCnt, gotErr, gotData, ra);
        vectors++;
        if (cyc !== eCyc || busyCnt !== eCyc || gotErr !== eErr || gotData !== expData[d] || ra !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL random dut%0d #%0d a=%h rd%b wr%b: got cyc=%0d busy=%0d err=%b data=%h after=%b, need cyc=%0d busy=%0d err=%b data=%h after=0",
                   d, n, addr, rd, wr, cyc, busyCnt, gotErr, gotData, ra, eCyc, eCyc, eErr, expData[d]);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_preload();
    test_write_read();
    test_errors();
    test_both_rw();
    test_back_to_back();
    test_latched_inputs();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory responder for the multicycle CPU: the slave end of the memory interface driven by the control unit's MemRead/MemWrite and the datapath's IorD-selected address. It accepts one word read or write at a time, spends a fixed number of wait cycles, then signals completion with a one-cycle MemReady pulse. It replaces the zero-wait combinational memory, so the control FSM must hold its memory state until MemReady.

## Interface
- LATENCY, 2: wait cycles between acceptance and completion; legal range 0..15.
- ADDR_W, 8: word-index width; storage holds 2**ADDR_W 32-bit words.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- Address  in  32  byte address from the IorD mux.
- WriteData  in  32  store data.
- MemRead  in  1  read request level.
- MemWrite  in  1  write request level.
- MemData  out  32  read data, registered; valid from the MemReady cycle of a read until the next read completes.
- MemReady  out  1  one-cycle completion pulse.
- MemBusy  out  1  high while a request is latched and not yet completed.
- MemError  out  1  high with MemReady when the request was rejected.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE: on an edge where MemRead or MemWrite is high, latch Address, WriteData and the operation. Inputs are ignored after latching.
  - Go to DONE if LATENCY=0 or the request is an error.
  - Otherwise go to WAIT with cnt=LATENCY-1.
- WAIT: if cnt=0, go to DONE and perform the access. Otherwise decrement cnt.
  - Read: the array word goes to the MemData register.
  - Write: the array word is written at this edge.
- DONE: MemReady=1 for exactly this cycle, then unconditionally return to IDLE. A request still high in DONE is not accepted until the IDLE edge, so every transfer is followed by a one-cycle bubble.
- Error conditions, checked on the latched request:
  - MemRead and MemWrite both high;
  - Address[1:0] != 0;
  - Address[31:ADDR_W+2] != 0.
- Error response: DONE with MemError=1; no array access; MemData unchanged.
- Word index = Address[ADDR_W+1:2].
- MemBusy=1 in WAIT and DONE.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - state IDLE, cnt=0;
  - MemData=0, MemReady=0, MemBusy=0, MemError=0;
  - array contents are not cleared.
- Reset during WAIT or DONE aborts the request. A pending write is never committed; a write already committed at the WAIT→DONE edge stays in the array.
- Let edge 0 be the edge that accepts a valid request. MemReady is high in the cycle after edge max(LATENCY,0):
  - LATENCY=0: the cycle after edge 0;
  - LATENCY=2: the cycle after edge 2.
- An error request always completes in the cycle after edge 0, regardless of LATENCY.
- Throughput: one transfer per LATENCY+2 cycles when requests are held continuously.
- All outputs are driven from registers; there is no combinational input→output path.

## Structure
- Package mem_pkg:
  - enum MemState {IDLE, WAIT, DONE};
  - localparam WORD_W=32;
  - the error-check function.
- Sub-module mem_array: 2**ADDR_W x 32, one synchronous write port, synchronous read into the MemData register. It has no reset. mem_responder instantiates it and drives its enables only at the WAIT→DONE (or IDLE→DONE) access edge.

## Test plan
- LATENCY=2, write 0xDEADBEEF to 0x10, then read 0x10 → MemReady in the cycle after edge 2 of each request; the read returns MemData=0xDEADBEEF; MemBusy is high for 3 cycles per request.
- LATENCY=0, back-to-back reads of 0x0 and 0x4 held high → MemReady pulses 2 cycles apart; exactly one pulse per request.
- Address 0x12 read, and Address 0x400 read (ADDR_W=8) → MemReady+MemError in the cycle after edge 0; MemData is unchanged.
- MemRead=MemWrite=1 at 0x8 → error response, and word 0x8 is unchanged on a later read.
- Write 0x11111111 to 0x20, with reset asserted in WAIT at cnt=1 → all outputs 0 immediately; a post-reset read of 0x20 returns the old value.
- Change Address and WriteData during WAIT → the access uses the values latched at edge 0.
